// File: rtl/reg_file_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_pkg
// Constants shared by the core: the register file, RoB, dispatcher and
// reservation stations all import these.
//   XLEN      : data width
//   REG_NUM   : number of architectural registers
//   REG_IDX_W : register index width
//   ROB_ID_W  : rename tag width (tag 0 means "value is valid")
//   NO_TAG    : tag value meaning no pending producer
//   REG_ZERO  : index of the hard-wired zero register
// ----------------------------------------------------------------------------
package reg_file_pkg;

  localparam int XLEN      = 32;
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_ID_W  = 5;

  localparam logic [ROB_ID_W-1:0]  NO_TAG   = '0;
  localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

endpackage : reg_file_pkg

// File: rtl/reg_file_read_port.sv
// ----------------------------------------------------------------------------
// reg_read_port
// One combinational operand read port with commit bypass.
//   rs          : register index being read
//   commit_flag : commit from the RoB is valid this cycle
//   commit_rd   : destination register of that commit
//   commit_q    : RoB id of the committing entry
//   commit_v    : committed value
//   q_rs, v_rs  : stored tag and value of register rs
//   q, v        : tag/value handed to the dispatcher
// ----------------------------------------------------------------------------
module reg_read_port
  import reg_file_pkg::*;
(
  input  logic [REG_IDX_W-1:0] rs,
  input  logic                 commit_flag,
  input  logic [REG_IDX_W-1:0] commit_rd,
  input  logic [ROB_ID_W-1:0]  commit_q,
  input  logic [XLEN-1:0]      commit_v,
  input  logic [ROB_ID_W-1:0]  q_rs,
  input  logic [XLEN-1:0]      v_rs,
  output logic [ROB_ID_W-1:0]  q,
  output logic [XLEN-1:0]      v
);

  always_comb begin
    q = q_rs;
    v = v_rs;
    if (rs == REG_ZERO) begin
      q = NO_TAG;
      v = '0;
    end else if (commit_flag && (commit_rd == rs) && (q_rs == commit_q)) begin
      // The producer the dispatcher would otherwise wait on is retiring right
      // now; forward its value so the dependency resolves this cycle.
      q = NO_TAG;
      v = commit_v;
    end
  end

endmodule : reg_read_port

// File: rtl/reg_file.sv
// ----------------------------------------------------------------------------
// reg_file
// Architectural register file with per-register rename tags.
//   clk_in, rst_in (sync, active-low), rdy_in (low = hold state)
//   Dispatcher read : rs1/rs2_from_dispatcher -> Q1/Q2, V1/V2_to_dispatcher
//   Dispatcher rename: en_rename/rd/rob_id_from_dispatcher
//   RoB commit      : commit_flag/rd/Q/V_from_rob
//   RoB rollback    : rollback_flag_from_rob clears every tag
// ----------------------------------------------------------------------------
module reg_file
  import reg_file_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic [REG_IDX_W-1:0] rs1_from_dispatcher,
  input  logic [REG_IDX_W-1:0] rs2_from_dispatcher,
  output logic [ROB_ID_W-1:0]  Q1_to_dispatcher,
  output logic [ROB_ID_W-1:0]  Q2_to_dispatcher,
  output logic [XLEN-1:0]      V1_to_dispatcher,
  output logic [XLEN-1:0]      V2_to_dispatcher,
  input  logic                 en_rename_from_dispatcher,
  input  logic [REG_IDX_W-1:0] rd_from_dispatcher,
  input  logic [ROB_ID_W-1:0]  rob_id_from_dispatcher,
  input  logic                 commit_flag_from_rob,
  input  logic [REG_IDX_W-1:0] rd_from_rob,
  input  logic [ROB_ID_W-1:0]  Q_from_rob,
  input  logic [XLEN-1:0]      V_from_rob,
  input  logic                 rollback_flag_from_rob
);

  logic [XLEN-1:0]     v_reg [REG_NUM];
  logic [ROB_ID_W-1:0] q_reg [REG_NUM];

  // Per-register decode of the commit and rename targets. Register 0 is never
  // written, so its decode is not generated.
  logic [REG_NUM-1:1] commit_hit;
  logic [REG_NUM-1:1] rename_hit;

  generate
    for (genvar gi = 1; gi < REG_NUM; gi++) begin : g_decode
      assign commit_hit[gi] = commit_flag_from_rob && (rd_from_rob == REG_IDX_W'(gi));
      // A rollback squashes the renaming instruction along with everything else.
      assign rename_hit[gi] = en_rename_from_dispatcher && !rollback_flag_from_rob &&
                              (rd_from_dispatcher == REG_IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        v_reg[i] <= '0;
        q_reg[i] <= NO_TAG;
      end
    end else if (rdy_in) begin
      for (int i = 1; i < REG_NUM; i++) begin
        // Retired values always land, even during a rollback.
        if (commit_hit[i])
          v_reg[i] <= V_from_rob;

        if (rollback_flag_from_rob)
          q_reg[i] <= NO_TAG;
        else if (rename_hit[i])
          q_reg[i] <= rob_id_from_dispatcher;
        else if (commit_hit[i] && (q_reg[i] == Q_from_rob))
          // Only clear when the committing entry is still the newest producer;
          // a younger rename's tag must survive.
          q_reg[i] <= NO_TAG;
      end
    end
  end

  reg_read_port u_read_port1 (
    .rs          (rs1_from_dispatcher),
    .commit_flag (commit_flag_from_rob),
    .commit_rd   (rd_from_rob),
    .commit_q    (Q_from_rob),
    .commit_v    (V_from_rob),
    .q_rs        (q_reg[rs1_from_dispatcher]),
    .v_rs        (v_reg[rs1_from_dispatcher]),
    .q           (Q1_to_dispatcher),
    .v           (V1_to_dispatcher)
  );

  reg_read_port u_read_port2 (
    .rs          (rs2_from_dispatcher),
    .commit_flag (commit_flag_from_rob),
    .commit_rd   (rd_from_rob),
    .commit_q    (Q_from_rob),
    .commit_v    (V_from_rob),
    .q_rs        (q_reg[rs2_from_dispatcher]),
    .v_rs        (v_reg[rs2_from_dispatcher]),
    .q           (Q2_to_dispatcher),
    .v           (V2_to_dispatcher)
  );

endmodule : reg_file
